aes_iter_encrypt: RTL and testbench

//  Iterative AES encryption core: one round per clock, all rounds including the final (no-MixColumns) round.
//  Key expansion is on the fly, so no key-schedule RAM; reuses existing subBytes/shiftRow/mixColumns blocks.

---
 rtl/aes_pkg.sv | 101 ++++++++++
 rtl/aes_iter_encrypt_key_step.sv | 38 +++
 rtl/aes_iter_encrypt.sv | 154 +++++++++++++++
 tb/tb_aes_iter_encrypt.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative encryption core: round counts,
// FSM state type, GF(2^8) helpers, S-box and the SubBytes/ShiftRows/MixColumns
// and key-schedule word functions.
package aes_pkg;

  localparam int NR128 = 10;
  localparam int NR256 = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // S-box computed as a^254 (multiplicative inverse, 0 -> 0) followed by the
  // affine transform; avoids carrying a 256-entry table in source.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant indexed by expansion step (0 -> 01).
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // State byte n = row + 4*col lives at bits [127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_iter_encrypt_key_step.sv
// One on-the-fly key expansion step: current key window in, next window and
// the four freshly generated words (the round key) out. Purely combinational.
// AES-128 (KEY_BITS=128): window is 4 words, replaced by the new 4 words.
// AES-256 (KEY_BITS=256): window is 8 words, shifts left by the new 4 words.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] kwin,
  input  logic                phase,      // 0: i%8==0 (RotWord+Rcon), 1: i%8==4 (SubWord only)
  input  logic [7:0]          rcon_byte,
  output logic [KEY_BITS-1:0] kwin_next,
  output logic [127:0]        rk
);

  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  // Generate w[i..i+3] from the oldest four words and the newest word.
  always_comb begin
    if (phase) t = sub_word(kwin[31:0]);
    else       t = sub_word(rot_word(kwin[31:0])) ^ {rcon_byte, 24'h000000};
    n0 = kwin[KEY_BITS-1  -: 32] ^ t;
    n1 = kwin[KEY_BITS-33 -: 32] ^ n0;
    n2 = kwin[KEY_BITS-65 -: 32] ^ n1;
    n3 = kwin[KEY_BITS-97 -: 32] ^ n2;
  end

  assign rk = {n0, n1, n2, n3};

  if (KEY_BITS == 256) begin : g_win256
    assign kwin_next = {kwin[127:0], rk};
  end else begin : g_win128
    assign kwin_next = rk;
  end

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES encryption core, one round per clock, key expanded on the fly.
// Optional feature macro: AES_LAST_KEY_OUT_EN -- adds the last_key output
// carrying the final round key alongside ct (decryption key seed).
module aes_iter_encrypt
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        pt,
  input  logic [KEY_BITS-1:0] key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ct
`ifdef AES_LAST_KEY_OUT_EN
  ,
  output logic [127:0]        last_key
`endif
);

  localparam int         NR   = (KEY_BITS == 256) ? NR256 : NR128;
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
  end

  state_t              state_q, state_d;
  logic [3:0]          round_q, round_d;
  logic [127:0]        st_q, st_d;
  logic [KEY_BITS-1:0] kwin_q, kwin_d;
  logic [127:0]        ct_q, ct_d;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0]        last_key_q, last_key_d;
`endif

  logic                phase;
  logic [3:0]          rcon_idx;
  logic [7:0]          rcon_byte;
  logic [KEY_BITS-1:0] step_kwin;
  logic [127:0]        step_rk;
  logic                use_stored;
  logic [127:0]        rk_sel;
  logic [KEY_BITS-1:0] kwin_adv;
  logic [127:0]        sb, sr, mc, round_out;

  // Expansion step position: AES-128 step = round-1; AES-256 generates from
  // round 2 on, with i = 4*round so the i%8 phase is the round's LSB.
  always_comb begin
    if (KEY_BITS == 256) begin
      phase    = round_q[0];
      rcon_idx = {1'b0, round_q[3:1]} - 4'd1;
    end else begin
      phase    = 1'b0;
      rcon_idx = round_q - 4'd1;
    end
  end

  assign rcon_byte = rcon(rcon_idx);

  aes_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .kwin      (kwin_q),
    .phase     (phase),
    .rcon_byte (rcon_byte),
    .kwin_next (step_kwin),
    .rk        (step_rk)
  );

  // AES-256 round 1 consumes the stored second key half; nothing to generate.
  assign use_stored = (KEY_BITS == 256) && (round_q == 4'd1);
  assign rk_sel     = use_stored ? kwin_q[127:0] : step_rk;
  assign kwin_adv   = use_stored ? kwin_q : step_kwin;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_bytes
    assign sb[8*gi +: 8] = sbox(st_q[8*gi +: 8]);
  end

  assign sr        = shift_rows(sb);
  assign mc        = mix_columns(sr);
  assign round_out = ((round_q == NR_L) ? sr : mc) ^ rk_sel;

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequencer.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    kwin_d  = kwin_q;
    ct_d    = ct_q;
`ifdef AES_LAST_KEY_OUT_EN
    last_key_d = last_key_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = pt ^ key[KEY_BITS-1 -: 128];
          kwin_d  = key;
          round_d = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d   = round_out;
        kwin_d = kwin_adv;
        if (round_q == NR_L) begin
          ct_d    = round_out;
`ifdef AES_LAST_KEY_OUT_EN
          last_key_d = rk_sel;
`endif
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      st_q    <= '0;
      kwin_q  <= '0;
      ct_q    <= '0;
`ifdef AES_LAST_KEY_OUT_EN
      last_key_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      kwin_q  <= kwin_d;
      ct_q    <= ct_d;
`ifdef AES_LAST_KEY_OUT_EN
      last_key_q <= last_key_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ct        = ct_q;
`ifdef AES_LAST_KEY_OUT_EN
  assign last_key  = last_key_q;
`endif

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Directed bench for aes_iter_encrypt: FIPS-197 vectors (AES-128 and AES-256),
// backpressure, back-to-back streaming and reset in the middle of a block.
// Honours AES_LAST_KEY_OUT_EN when the build defines it.
module tb_aes_iter_encrypt;

  localparam logic [127:0] V1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V2_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V2_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [255:0] V3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] V3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv_a, ir_a, ov_a, or_a;
  logic [127:0] pt_a, key_a, ct_a;
  logic         iv_b, ir_b, ov_b, or_b;
  logic [127:0] pt_b, ct_b;
  logic [255:0] key_b;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] lk_a, lk_b;
`endif

  int checks   = 0;
  int failures = 0;

  logic [127:0] bb_pt [3];
  logic [127:0] bb_key[3];
  logic [127:0] bb_ct [3];
  int           acc_cyc[3];
  int           nacc, ndone, cyc;
  bit           acc, any_ov;
  logic [127:0] held_ct;

  aes_iter_encrypt #(.KEY_BITS(128)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .pt(pt_a), .key(key_a),
    .out_valid(ov_a), .out_ready(or_a), .ct(ct_a)
`ifdef AES_LAST_KEY_OUT_EN
    , .last_key(lk_a)
`endif
  );

  aes_iter_encrypt #(.KEY_BITS(256)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .pt(pt_b), .key(key_b),
    .out_valid(ov_b), .out_ready(or_b), .ct(ct_b)
`ifdef AES_LAST_KEY_OUT_EN
    , .last_key(lk_b)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one block, then check out_valid timing and ct. Counting the
  // presentation cycle as cycle 0, out_valid must first be high at NR+1.
  task automatic run_vec(input bit b256, input logic [127:0] p, input logic [255:0] k,
                         input logic [127:0] exp, input string tag);
    int nr;
    nr = b256 ? 14 : 10;
    if (b256) begin pt_b = p; key_b = k; iv_b = 1'b1; end
    else      begin pt_a = p; key_a = k[255:128]; iv_a = 1'b1; end
    chk({tag, "_ready_idle"}, 128'(b256 ? ir_b : ir_a), 128'(1));
    tick();
    iv_a = 1'b0;
    iv_b = 1'b0;
    chk({tag, "_ready_busy"}, 128'(b256 ? ir_b : ir_a), 128'(0));
    repeat (nr - 1) tick();
    chk({tag, "_valid_early"}, 128'(b256 ? ov_b : ov_a), 128'(0));
    tick();
    chk({tag, "_valid"}, 128'(b256 ? ov_b : ov_a), 128'(1));
    chk({tag, "_ct"}, b256 ? ct_b : ct_a, exp);
  endtask

  task automatic release_out(input bit b256, input string tag);
    if (b256) or_b = 1'b1; else or_a = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 128'(b256 ? ov_b : ov_a), 128'(0));
    chk({tag, "_ready_back"}, 128'(b256 ? ir_b : ir_a), 128'(1));
    or_a = 1'b0;
    or_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    iv_a = 1'b0; or_a = 1'b0; pt_a = '0; key_a = '0;
    iv_b = 1'b0; or_b = 1'b0; pt_b = '0; key_b = '0;
    bb_pt[0] = V1_PT; bb_key[0] = V1_KEY; bb_ct[0] = V1_CT;
    bb_pt[1] = V2_PT; bb_key[1] = V2_KEY; bb_ct[1] = V2_CT;
    bb_pt[2] = V1_PT; bb_key[2] = V1_KEY; bb_ct[2] = V1_CT;
    for (int i = 0; i < 3; i++) acc_cyc[i] = 0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid_a", 128'(ov_a), 128'(0));
    chk("rst_in_ready_a", 128'(ir_a), 128'(1));
    chk("rst_ct_a", ct_a, 128'h0);
    chk("rst_out_valid_b", 128'(ov_b), 128'(0));
    chk("rst_ct_b", ct_b, 128'h0);
`ifdef AES_LAST_KEY_OUT_EN
    chk("rst_last_key_a", lk_a, 128'h0);
`endif
    rst = 1'b0;
    tick();

    // FIPS-197 App.B, AES-128
    run_vec(1'b0, V1_PT, {V1_KEY, 128'h0}, V1_CT, "appb");
    release_out(1'b0, "appb");

    // FIPS-197 App.C.1, AES-128
    run_vec(1'b0, V2_PT, {V2_KEY, 128'h0}, V2_CT, "c1");
`ifdef AES_LAST_KEY_OUT_EN
    chk("c1_last_key", lk_a, V2_LK);
`endif
    release_out(1'b0, "c1");

    // FIPS-197 App.C.3, AES-256
    run_vec(1'b1, V2_PT, V3_KEY, V3_CT, "c3");
    release_out(1'b1, "c3");

    // Backpressure: DONE held 20 cycles while in_valid pulses are offered
    run_vec(1'b0, V1_PT, {V1_KEY, 128'h0}, V1_CT, "bp");
    held_ct = V1_CT;
    for (int i = 0; i < 20; i++) begin
      iv_a = i[0];
      pt_a = {$urandom, $urandom, $urandom, $urandom};
      tick();
      chk($sformatf("bp_valid_%0d", i), 128'(ov_a), 128'(1));
      chk($sformatf("bp_ct_%0d", i), ct_a, held_ct);
      chk($sformatf("bp_ready_%0d", i), 128'(ir_a), 128'(0));
    end
    iv_a = 1'b0;
    release_out(1'b0, "bp");
    chk("bp_ct_kept", ct_a, held_ct);
    tick();
    chk("bp_no_queued_accept", 128'(ir_a), 128'(1));

    // Back-to-back: in_valid and out_ready held high over three blocks
    pt_a = bb_pt[0]; key_a = bb_key[0]; iv_a = 1'b1; or_a = 1'b1;
    nacc = 0; ndone = 0; cyc = 0;
    while (ndone < 3 && cyc < 100) begin
      acc = iv_a && ir_a;
      if (ov_a) begin
        chk($sformatf("b2b_ct%0d", ndone), ct_a, bb_ct[ndone]);
        ndone++;
      end
      tick();
      cyc++;
      if (acc && nacc < 3) begin
        acc_cyc[nacc] = cyc;
        nacc++;
        if (nacc < 3) begin pt_a = bb_pt[nacc]; key_a = bb_key[nacc]; end
        else iv_a = 1'b0;
      end
    end
    iv_a = 1'b0;
    or_a = 1'b0;
    chk("b2b_blocks", 128'(ndone), 128'(3));
    chk("b2b_gap01", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12));
    chk("b2b_gap12", 128'(acc_cyc[2] - acc_cyc[1]), 128'(12));
    tick();

    // Reset while RUN is at round 5 aborts the block
    pt_a = V2_PT; key_a = V2_KEY; iv_a = 1'b1;
    tick();
    iv_a = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 128'(ov_a), 128'(0));
    chk("mid_rst_ready", 128'(ir_a), 128'(1));
    chk("mid_rst_ct", ct_a, 128'h0);
    any_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      any_ov = any_ov | ov_a;
    end
    chk("mid_rst_never_valid", 128'(any_ov), 128'(0));
    run_vec(1'b0, V1_PT, {V1_KEY, 128'h0}, V1_CT, "post_rst");
    release_out(1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
